// File: rtl/sprite_path_pkg.sv
// Shared types, FSM encoding and the default walkable-region table for sprite_path_mover.
package sprite_path_pkg;

    localparam int CW          = 12;
    localparam int MAX_REGIONS = 16;

    typedef enum logic [1:0] {NONE, BOX, SUM, DIFF} region_kind_t;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_SCAN, ST_ERASE, ST_UPDATE, ST_DRAW
    } state_t;

    typedef struct packed {
        region_kind_t         kind;
        logic signed [CW-1:0] xmin;
        logic signed [CW-1:0] xmax;
        logic signed [CW-1:0] lo;
        logic signed [CW-1:0] hi;
        logic                 tp;
        logic [CW-1:0]        tpx;
        logic [CW-1:0]        tpy;
    } region_t;

    function automatic region_t mk_region(region_kind_t kind, int xmin, int xmax,
                                          int lo, int hi, bit tp, int tpx, int tpy);
        region_t r;
        r.kind = kind;
        r.xmin = CW'(xmin);
        r.xmax = CW'(xmax);
        r.lo   = CW'(lo);
        r.hi   = CW'(hi);
        r.tp   = tp;
        r.tpx  = CW'(tpx);
        r.tpy  = CW'(tpy);
        return r;
    endfunction

    // Entries past the configured NUM_REGIONS are never scanned.
    localparam region_t REGIONS [0:MAX_REGIONS-1] = '{
        mk_region(BOX,  121, 121,  193,  198, 1'b1, 126, 68),
        mk_region(SUM,   90, 123,  314,  319, 1'b0,   0,  0),
        mk_region(DIFF, 200, 300, -200, -150, 1'b0,   0,  0),
        mk_region(BOX,   10,  40,   20,   60, 1'b0,   0,  0),
        mk_region(SUM,    0,  60,  100,  140, 1'b0,   0,  0),
        mk_region(BOX,  250, 310,  100,  120, 1'b0,   0,  0),
        mk_region(DIFF,   5,  40,   50,   80, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0),
        mk_region(NONE,   0,   0,    0,    0, 1'b0,   0,  0)
    };

endpackage

// File: rtl/sprite_path_mover_region_match.sv
// Combinational test of one region entry against a signed candidate position.
module sprite_region_match
    import sprite_path_pkg::*;
(
    input  region_t              ent,
    input  logic signed [CW-1:0] nx,
    input  logic signed [CW-1:0] ny,
    output logic                 match,
    output logic                 tp,
    output logic [CW-1:0]        tpx,
    output logic [CW-1:0]        tpy
);

    logic signed [CW-1:0] xmin, xmax, lo, hi;
    logic signed [CW:0]   lo_e, hi_e, sum, diff;
    logic                 in_x;

    assign xmin = ent.xmin;
    assign xmax = ent.xmax;
    assign lo   = ent.lo;
    assign hi   = ent.hi;
    // One extra bit so nx+ny and ny-nx never wrap.
    assign lo_e = {lo[CW-1], lo};
    assign hi_e = {hi[CW-1], hi};
    assign sum  = {nx[CW-1], nx} + {ny[CW-1], ny};
    assign diff = {ny[CW-1], ny} - {nx[CW-1], nx};
    assign in_x = (nx >= xmin) && (nx <= xmax);

    always_comb begin
        match = 1'b0;
        case (ent.kind)
            BOX:     match = in_x && (ny >= lo) && (ny <= hi);
            SUM:     match = in_x && (sum >= lo_e) && (sum <= hi_e);
            DIFF:    match = in_x && (diff >= lo_e) && (diff <= hi_e);
            default: match = 1'b0;
        endcase
    end

    assign tp  = ent.tp;
    assign tpx = ent.tpx;
    assign tpy = ent.tpy;

endmodule

// File: rtl/sprite_path_mover.sv
// Sprite mover: tick-paced moves validated against a region table, then erase/draw handshakes.
// Optional one-deep move queue when SPRITE_MOVE_QUEUE_EN is defined.
module sprite_path_mover
    import sprite_path_pkg::*;
#(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int STEP        = 1,
    parameter int TICK_DIV    = 6250000,
    parameter int START_X     = 95,
    parameter int START_Y     = 221,
    parameter int NUM_REGIONS = 8
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           move,
    input  logic [1:0]     dir,
    input  logic           done_bg,
    input  logic           done_char,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           draw_bg,
    output logic           draw_char,
    output logic           busy,
    output logic           blocked
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [CW-1:0] SW_C   = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] SH_C   = CW'(SCREEN_H);
    localparam logic signed [CW-1:0] ZERO_C = '0;
    localparam logic signed [X_W:0]  STEP_X = (X_W+1)'(STEP);
    localparam logic signed [Y_W:0]  STEP_Y = (Y_W+1)'(STEP);

    state_t               state, state_n;
    logic [TW-1:0]        cnt;
    logic                 tick;
    logic [3:0]           idx;
    logic [1:0]           dir_sel;
    logic                 pend, take_slot, accept, hit, db_n, dc_n, off_screen, last;
    logic signed [X_W:0]  cx, nx_s;
    logic signed [Y_W:0]  cy, ny_s;
    logic signed [CW-1:0] nx_c, ny_c, nx_r, ny_r;
    region_t              ent;
    logic                 m_match, m_tp;
    logic [CW-1:0]        m_tpx, m_tpy;
    logic                 tp_r;
    logic [X_W-1:0]       tpx_r;
    logic [Y_W-1:0]       tpy_r;
    logic                 unused_tp_hi;

    assign tick = (cnt == TW'(TICK_DIV - 1));
    assign busy = (state != ST_IDLE);

`ifdef SPRITE_MOVE_QUEUE_EN
    logic       slot_full;
    logic [1:0] slot_dir;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            slot_full <= 1'b0;
        end else if (take_slot) begin
            slot_full <= 1'b0;
        end else if (busy && tick && move && !slot_full) begin
            slot_full <= 1'b1;
            slot_dir  <= dir;
        end
    end

    assign pend    = slot_full;
    assign dir_sel = slot_full ? slot_dir : dir;
`else
    assign pend    = 1'b0;
    assign dir_sel = dir;
`endif

    assign cx   = {1'b0, x};
    assign cy   = {1'b0, y};
    assign nx_s = dir_sel[0] ? cx - STEP_X : cx + STEP_X;
    assign ny_s = dir_sel[1] ? cy - STEP_Y : cy + STEP_Y;
    assign nx_c = {{(CW-X_W-1){nx_s[X_W]}}, nx_s};
    assign ny_c = {{(CW-Y_W-1){ny_s[Y_W]}}, ny_s};

    assign ent = REGIONS[idx];

    sprite_region_match u_match (
        .ent   (ent),
        .nx    (nx_r),
        .ny    (ny_r),
        .match (m_match),
        .tp    (m_tp),
        .tpx   (m_tpx),
        .tpy   (m_tpy)
    );

    assign unused_tp_hi = ^{m_tpx[CW-1:X_W], m_tpy[CW-1:Y_W]};
    assign off_screen   = (nx_r <= ZERO_C) || (nx_r >= SW_C) || (ny_r <= ZERO_C) || (ny_r >= SH_C);
    assign last         = (idx == 4'(NUM_REGIONS - 1));

    always_comb begin
        state_n   = state;
        db_n      = 1'b0;
        dc_n      = 1'b0;
        blocked   = 1'b0;
        accept    = 1'b0;
        take_slot = 1'b0;
        hit       = 1'b0;
        case (state)
            ST_INIT: begin
                if (draw_char && done_char) state_n = ST_IDLE;
                else                        dc_n    = 1'b1;
            end
            ST_IDLE: begin
                if (pend) begin
                    accept    = 1'b1;
                    take_slot = 1'b1;
                    state_n   = ST_SCAN;
                end else if (move && tick) begin
                    accept  = 1'b1;
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Off-screen wins over any region that would otherwise match.
                if (((idx == 4'd0) && off_screen) || (!m_match && last)) begin
                    blocked = 1'b1;
                    state_n = ST_IDLE;
                end else if (m_match) begin
                    hit     = 1'b1;
                    db_n    = 1'b1;
                    state_n = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (draw_bg && done_bg) state_n = ST_UPDATE;
                else                    db_n    = 1'b1;
            end
            ST_UPDATE: begin
                dc_n    = 1'b1;
                state_n = ST_DRAW;
            end
            ST_DRAW: begin
                if (draw_char && done_char) state_n = ST_IDLE;
                else                        dc_n    = 1'b1;
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= ST_INIT;
            x         <= X_W'(START_X);
            y         <= Y_W'(START_Y);
            draw_bg   <= 1'b0;
            draw_char <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else begin
            state     <= state_n;
            draw_bg   <= db_n;
            draw_char <= dc_n;
            cnt       <= tick ? '0 : cnt + TW'(1);
            if (accept)              idx <= '0;
            else if (state == ST_SCAN) idx <= idx + 4'd1;
            if (state == ST_UPDATE) begin
                x <= tp_r ? tpx_r : nx_r[X_W-1:0];
                y <= tp_r ? tpy_r : ny_r[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            nx_r <= nx_c;
            ny_r <= ny_c;
        end
        if (hit) begin
            tp_r  <= m_tp;
            tpx_r <= m_tpx[X_W-1:0];
            tpy_r <= m_tpy[Y_W-1:0];
        end
    end

endmodule

// File: tb/tb_sprite_path_mover.sv
// Bench for sprite_path_mover: four instances with different start points, directed and random moves.
module tb_sprite_path_mover;
    import sprite_path_pkg::*;

    localparam int TD = 8;
    localparam int NR = 8;

    logic       clock = 1'b0;
    logic       resetn;
    logic       mv  [4];
    logic [1:0] dr  [4];
    logic       dbg [4];
    logic       dch [4];
    logic [8:0] xo  [4];
    logic [7:0] yo  [4];
    logic       dbo [4];
    logic       dco [4];
    logic       bsy [4];
    logic       blk [4];

    int checks = 0;
    int errors = 0;
    int mx [4];
    int my [4];
    int sx [4] = '{95, 123, 120, 1};
    int sy [4] = '{221, 193, 196, 5};
    bit bg_seen = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) if (dbo[0] === 1'b1) bg_seen <= 1'b1;

    sprite_path_mover #(.TICK_DIV(TD), .START_X(95), .START_Y(221)) u_a (
        .clock(clock), .resetn(resetn), .move(mv[0]), .dir(dr[0]), .done_bg(dbg[0]),
        .done_char(dch[0]), .x(xo[0]), .y(yo[0]), .draw_bg(dbo[0]), .draw_char(dco[0]),
        .busy(bsy[0]), .blocked(blk[0]));
    sprite_path_mover #(.TICK_DIV(TD), .START_X(123), .START_Y(193)) u_b (
        .clock(clock), .resetn(resetn), .move(mv[1]), .dir(dr[1]), .done_bg(dbg[1]),
        .done_char(dch[1]), .x(xo[1]), .y(yo[1]), .draw_bg(dbo[1]), .draw_char(dco[1]),
        .busy(bsy[1]), .blocked(blk[1]));
    sprite_path_mover #(.TICK_DIV(TD), .START_X(120), .START_Y(196)) u_c (
        .clock(clock), .resetn(resetn), .move(mv[2]), .dir(dr[2]), .done_bg(dbg[2]),
        .done_char(dch[2]), .x(xo[2]), .y(yo[2]), .draw_bg(dbo[2]), .draw_char(dco[2]),
        .busy(bsy[2]), .blocked(blk[2]));
    sprite_path_mover #(.TICK_DIV(TD), .START_X(1), .START_Y(5)) u_d (
        .clock(clock), .resetn(resetn), .move(mv[3]), .dir(dr[3]), .done_bg(dbg[3]),
        .done_char(dch[3]), .x(xo[3]), .y(yo[3]), .draw_bg(dbo[3]), .draw_char(dco[3]),
        .busy(bsy[3]), .blocked(blk[3]));

    // Outcome of one move from the rules: position after it, accepted or not, scan cycles taken.
    function automatic void model(input int x, input int y, input logic [1:0] d,
                                  output int ex, output int ey, output bit acc, output int lat);
        int nx, ny, xmin, xmax, lo, hi;
        bit m;
        nx = d[0] ? x - 1 : x + 1;
        ny = d[1] ? y - 1 : y + 1;
        ex = x; ey = y; acc = 1'b0; lat = NR;
        if (nx <= 0 || nx >= 320 || ny <= 0 || ny >= 240) begin
            lat = 1;
            return;
        end
        for (int i = 0; i < NR; i++) begin
            xmin = $signed(REGIONS[i].xmin);
            xmax = $signed(REGIONS[i].xmax);
            lo   = $signed(REGIONS[i].lo);
            hi   = $signed(REGIONS[i].hi);
            m = 1'b0;
            if (REGIONS[i].kind == BOX)  m = nx >= xmin && nx <= xmax && ny >= lo && ny <= hi;
            if (REGIONS[i].kind == SUM)  m = nx >= xmin && nx <= xmax && nx + ny >= lo && nx + ny <= hi;
            if (REGIONS[i].kind == DIFF) m = nx >= xmin && nx <= xmax && ny - nx >= lo && ny - nx <= hi;
            if (m) begin
                acc = 1'b1;
                lat = i + 1;
                ex  = REGIONS[i].tp ? int'(REGIONS[i].tpx) : nx;
                ey  = REGIONS[i].tp ? int'(REGIONS[i].tpy) : ny;
                return;
            end
        end
    endfunction

    task automatic run_move(input int u, input logic [1:0] d, input int bgd, input int chd,
                            output int got, output int k);
        int ex, ey, lat, n;
        bit acc;
        model(mx[u], my[u], d, ex, ey, acc, lat);
        got = 0; k = 0;
        mv[u] = 1'b1; dr[u] = d;
        n = 0;
        while (bsy[u] !== 1'b1 && n < 4 * TD) begin @(negedge clock); n++; end
        mv[u] = 1'b0;
        checks++;
        if (bsy[u] !== 1'b1) begin
            errors++;
            $display("FAIL accept u=%0d busy=%b required 1", u, bsy[u]);
            return;
        end
        k = 1;
        while (k <= 20) begin
            if (blk[u] === 1'b1) begin got = 1; break; end
            if (dbo[u] === 1'b1) begin got = 2; break; end
            @(negedge clock); k++;
        end
        checks++;
        if (got != (acc ? 2 : 1) || k != (acc ? lat + 1 : lat)) begin
            errors++;
            $display("FAIL outcome u=%0d got=%0d at %0d required %0d at %0d", u, got, k,
                     acc ? 2 : 1, acc ? lat + 1 : lat);
        end
        if (got == 1) begin
            @(negedge clock);
            checks++;
            if (bsy[u] !== 1'b0 || xo[u] !== mx[u] || yo[u] !== my[u] || dbo[u] !== 1'b0 || dco[u] !== 1'b0) begin
                errors++;
                $display("FAIL after_block u=%0d busy=%b x=%0d y=%0d bg=%b ch=%b required 0 %0d %0d 0 0",
                         u, bsy[u], xo[u], yo[u], dbo[u], dco[u], mx[u], my[u]);
            end
        end else if (got == 2) begin
            checks++;
            if (xo[u] !== mx[u] || yo[u] !== my[u]) begin
                errors++;
                $display("FAIL erase_pos u=%0d x=%0d y=%0d required %0d %0d", u, xo[u], yo[u], mx[u], my[u]);
            end
            repeat (bgd) @(negedge clock);
            dbg[u] = 1'b1; @(negedge clock); dbg[u] = 1'b0;
            n = 0;
            while (dco[u] !== 1'b1 && n < 20) begin @(negedge clock); n++; end
            checks++;
            if (dco[u] !== 1'b1 || dbo[u] !== 1'b0 || xo[u] !== ex || yo[u] !== ey) begin
                errors++;
                $display("FAIL draw_pos u=%0d ch=%b bg=%b x=%0d y=%0d required 1 0 %0d %0d",
                         u, dco[u], dbo[u], xo[u], yo[u], ex, ey);
            end
            repeat (chd) @(negedge clock);
            dch[u] = 1'b1; @(negedge clock); dch[u] = 1'b0;
            checks++;
            if (bsy[u] !== 1'b0 || dco[u] !== 1'b0) begin
                errors++;
                $display("FAIL draw_end u=%0d busy=%b ch=%b required 0 0", u, bsy[u], dco[u]);
            end
        end
        mx[u] = ex; my[u] = ey;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin mv[i] = 0; dr[i] = 0; dbg[i] = 0; dch[i] = 0; end
        repeat (3) @(negedge clock);
        checks++;
        if (dbo[0] !== 1'b0 || dco[0] !== 1'b0 || blk[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl bg=%b ch=%b blk=%b busy=%b required 0 0 0 1", dbo[0], dco[0], blk[0], bsy[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xo[i] !== sx[i] || yo[i] !== sy[i]) begin
                errors++;
                $display("FAIL reset_pos u=%0d x=%0d y=%0d required %0d %0d", i, xo[i], yo[i], sx[i], sy[i]);
            end
            mx[i] = sx[i]; my[i] = sy[i];
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (dco[0] !== 1'b1 || bsy[0] !== 1'b1) begin
                errors++;
                $display("FAIL init_draw cyc=%0d ch=%b busy=%b required 1 1", c, dco[0], bsy[0]);
            end
        end
        for (int i = 0; i < 4; i++) dch[i] = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) dch[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dco[i] !== 1'b0 || bsy[i] !== 1'b0) begin
                errors++;
                $display("FAIL init_done u=%0d ch=%b busy=%b required 0 0", i, dco[i], bsy[i]);
            end
        end
        checks++;
        if (bg_seen !== 1'b0) begin
            errors++;
            $display("FAIL init_no_bg seen=%b required 0", bg_seen);
        end
    endtask

    task automatic test_region_sum();
        int got, k;
        run_move(0, 2'b10, 2, 1, got, k);
        checks++;
        if (got != 2 || xo[0] !== 9'd96 || yo[0] !== 8'd220) begin
            errors++;
            $display("FAIL sum_move got=%0d x=%0d y=%0d required 2 96 220", got, xo[0], yo[0]);
        end
    endtask

    task automatic test_no_match();
        int got, k;
        run_move(1, 2'b00, 0, 0, got, k);
        checks++;
        if (got != 1 || k != 8 || xo[1] !== 9'd123 || yo[1] !== 8'd193) begin
            errors++;
            $display("FAIL no_match got=%0d k=%0d x=%0d y=%0d required 1 8 123 193", got, k, xo[1], yo[1]);
        end
    endtask

    task automatic test_teleport();
        int got, k;
        run_move(2, 2'b00, 0, 3, got, k);
        checks++;
        if (got != 2 || k != 2 || xo[2] !== 9'd126 || yo[2] !== 8'd68) begin
            errors++;
            $display("FAIL teleport got=%0d k=%0d x=%0d y=%0d required 2 2 126 68", got, k, xo[2], yo[2]);
        end
    endtask

    task automatic test_offscreen();
        int got, k;
        run_move(3, 2'b01, 0, 0, got, k);
        checks++;
        if (got != 1 || k != 1 || xo[3] !== 9'd1 || yo[3] !== 8'd5) begin
            errors++;
            $display("FAIL offscreen got=%0d k=%0d x=%0d y=%0d required 1 1 1 5", got, k, xo[3], yo[3]);
        end
    endtask

    task automatic serve_a(output bit ok);
        int n;
        ok = 1'b0;
        dbg[0] = 1'b1; @(negedge clock); dbg[0] = 1'b0;
        n = 0;
        while (dco[0] !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        if (dco[0] !== 1'b1) return;
        dch[0] = 1'b1; @(negedge clock); dch[0] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_queue();
        int n, moves, want, ex, ey, lat;
        bit ok, acc;
`ifdef SPRITE_MOVE_QUEUE_EN
        want = 2;
`else
        want = 1;
`endif
        moves = 0;
        mv[0] = 1'b1; dr[0] = 2'b10;
        n = 0;
        while (dbo[0] !== 1'b1 && n < 6 * TD) begin @(negedge clock); n++; end
        checks++;
        if (dbo[0] !== 1'b1) begin
            errors++; mv[0] = 1'b0;
            $display("FAIL queue_first draw_bg=%b required 1", dbo[0]);
            return;
        end
        repeat (2 * TD + 2) @(negedge clock);
        mv[0] = 1'b0;
        serve_a(ok);
        if (ok) moves++;
        n = 0;
        while (n < 3 * TD) begin
            @(negedge clock); n++;
            if (dbo[0] === 1'b1) begin
                serve_a(ok);
                if (ok) moves++;
                n = 0;
            end
        end
        for (int i = 0; i < want; i++) begin
            model(mx[0], my[0], 2'b10, ex, ey, acc, lat);
            mx[0] = ex; my[0] = ey;
        end
        checks++;
        if (moves != want || xo[0] !== mx[0] || yo[0] !== my[0]) begin
            errors++;
            $display("FAIL queue moves=%0d x=%0d y=%0d required %0d %0d %0d", moves, xo[0], yo[0], want, mx[0], my[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mv[0] = 1'b1; dr[0] = 2'b10;
        n = 0;
        while (dbo[0] !== 1'b1 && n < 6 * TD) begin @(negedge clock); n++; end
        mv[0] = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (dbo[0] !== 1'b0 || dco[0] !== 1'b0 || bsy[0] !== 1'b1 || xo[0] !== 9'd95 || yo[0] !== 8'd221) begin
            errors++;
            $display("FAIL reset_mid bg=%b ch=%b busy=%b x=%0d y=%0d required 0 0 1 95 221",
                     dbo[0], dco[0], bsy[0], xo[0], yo[0]);
        end
        resetn = 1'b1;
        n = 0;
        while (dco[0] !== 1'b1 && n < 5) begin @(negedge clock); n++; end
        for (int i = 0; i < 4; i++) begin dch[i] = 1'b1; mx[i] = sx[i]; my[i] = sy[i]; end
        @(negedge clock);
        for (int i = 0; i < 4; i++) dch[i] = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_reinit busy=%b required 0", bsy[0]);
        end
    endtask

    task automatic test_random();
        int got, k;
        for (int t = 0; t < 30; t++) begin
            run_move(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), got, k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_region_sum();
        test_no_match();
        test_teleport();
        test_offscreen();
        test_queue();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
